hmac_msg_padder: RTL and testbench

//  Message-side initiator for hmac_core: packs a 32-bit big-endian word stream into 1024-bit blocks.

---
 rtl/hmac_pad_pkg.sv | 49 ++++
 rtl/hmac_msg_padder.sv | 175 +++++++++++++++++
 tb/tb_hmac_msg_padder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hmac_pad_pkg.sv
// Shared types, constants and the padding helper for the HMAC message padder.
package hmac_pad_pkg;

  localparam int unsigned BLOCK_BYTES = 128;
  localparam int unsigned PAD_LIMIT   = 111;
  localparam int unsigned LEN_FIELD_W = 128;
  localparam int unsigned IPAD_BITS   = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Which trailer block, if any, is still owed after the current one.
  typedef enum logic [1:0] {
    ExtraNone,
    ExtraZeros,  // zeros plus length field
    ExtraMark    // 0x80 at byte 0, zeros, length field
  } extra_e;

  // Builds the block to hand to the core from the data buffer, the byte pointer
  // just past the data, the length field and any pending trailer selection.
  function automatic logic [1023:0] pad_block(input logic [1023:0]            blk,
                                              input logic [7:0]               p,
                                              input logic [LEN_FIELD_W-1:0]   len,
                                              input extra_e                   extra_sel);
    logic [1023:0] mark;
    logic [1023:0] res;
    mark = {8'h80, {1016{1'b0}}} >> {p, 3'b000};
    res  = blk;
    unique case (extra_sel)
      ExtraZeros: res = {{(1024 - LEN_FIELD_W){1'b0}}, len};
      ExtraMark:  res = {8'h80, {(1016 - LEN_FIELD_W){1'b0}}, len};
      default: begin
        if (p <= 8'(PAD_LIMIT)) begin
          res = blk | mark | {{(1024 - LEN_FIELD_W){1'b0}}, len};
        end else if (p < 8'(BLOCK_BYTES)) begin
          res = blk | mark;
        end
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hmac_msg_padder.sv
// Packs a big-endian 32-bit word stream into SHA-384 padded 1024-bit blocks and
// drives init/next commands to hmac_core. The length field accounts for the
// key^ipad block the core hashes first.
module hmac_msg_padder
  import hmac_pad_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          zeroize,
  input  logic          start,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [31:0]   msg_data,
  input  logic          msg_last,
  input  logic [1:0]    msg_last_bytes,
  input  logic          msg_empty,
  output logic          core_init,
  output logic          core_next,
  output logic [1023:0] core_block,
  input  logic          core_ready,
  input  logic          core_tag_valid,
  output logic          busy,
  output logic          done
);

  state_e               state_q;
  extra_e               extra_q;
  logic [7:0]           byte_ptr_q;
  logic [LEN_W-1:0]     bit_len_q;
  logic                 first_q;
  logic                 final_q;
  logic [1:0]           wait_cnt_q;
  logic [1023:0]        block_q;
  logic                 core_init_q;
  logic                 core_next_q;
  logic                 done_q;

  logic [2:0]             word_bytes;
  logic [31:0]            word_masked;
  logic [1023:0]          word_placed;
  logic [LEN_FIELD_W-1:0] len_field;
  logic [1023:0]          pad_out;

  // Byte-enable packing of the incoming word and the padded block candidate.
  always_comb begin
    word_bytes = (msg_last && (msg_last_bytes != 2'd0)) ? {1'b0, msg_last_bytes} : 3'd4;
    word_masked = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < word_bytes) begin
        word_masked[31-8*k -: 8] = msg_data[31-8*k -: 8];
      end
    end
    word_placed = {word_masked, 992'b0} >> {byte_ptr_q[6:0], 3'b000};
    len_field   = LEN_FIELD_W'(IPAD_BITS) + LEN_FIELD_W'(bit_len_q);
    pad_out     = pad_block(block_q, byte_ptr_q, len_field, extra_q);
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    msg_ready = (state_q == StFill) && (byte_ptr_q < 8'(BLOCK_BYTES));
    busy      = (state_q != StIdle);
  end

  assign core_init  = core_init_q;
  assign core_next  = core_next_q;
  assign core_block = block_q;
  assign done       = done_q;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      extra_q     <= ExtraNone;
      byte_ptr_q  <= '0;
      bit_len_q   <= '0;
      first_q     <= 1'b1;
      final_q     <= 1'b0;
      wait_cnt_q  <= '0;
      block_q     <= '0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (zeroize) begin
      state_q     <= StIdle;
      extra_q     <= ExtraNone;
      byte_ptr_q  <= '0;
      bit_len_q   <= '0;
      first_q     <= 1'b1;
      final_q     <= 1'b0;
      wait_cnt_q  <= '0;
      block_q     <= '0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            block_q    <= '0;
            byte_ptr_q <= '0;
            bit_len_q  <= '0;
            first_q    <= 1'b1;
            final_q    <= 1'b0;
            extra_q    <= ExtraNone;
            state_q    <= msg_empty ? StPad : StFill;
          end
        end
        StFill: begin
          if (msg_valid && msg_ready) begin
            block_q    <= block_q | word_placed;
            byte_ptr_q <= byte_ptr_q + {5'b0, word_bytes};
            bit_len_q  <= bit_len_q + LEN_W'({word_bytes, 3'b000});
            if (msg_last) begin
              state_q <= StPad;
            end else if (byte_ptr_q == 8'(BLOCK_BYTES - 4)) begin
              state_q <= StIssue;
            end
          end
        end
        StPad: begin
          block_q <= pad_out;
          if (extra_q != ExtraNone) begin
            final_q <= 1'b1;
            extra_q <= ExtraNone;
          end else if (byte_ptr_q <= 8'(PAD_LIMIT)) begin
            final_q <= 1'b1;
          end else if (byte_ptr_q < 8'(BLOCK_BYTES)) begin
            extra_q <= ExtraZeros;
          end else begin
            extra_q <= ExtraMark;
          end
          state_q <= StIssue;
        end
        StIssue: begin
          if (core_ready) begin
            core_init_q <= first_q;
            core_next_q <= !first_q;
            first_q     <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          // Skip the pulse cycle and the one after it; core_ready may lag the command.
          if (wait_cnt_q != 2'd2) begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end else if (core_ready && core_tag_valid) begin
            block_q    <= '0;
            byte_ptr_q <= '0;
            if (final_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (extra_q != ExtraNone) begin
              state_q <= StPad;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_msg_padder.sv
// Self-checking bench for hmac_msg_padder: a byte-level SHA-384 padding model
// predicts every block and command; a small core responder records them.
module tb_hmac_msg_padder;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          zeroize = 1'b0;
  logic          start = 1'b0;
  logic          msg_valid = 1'b0;
  logic          msg_ready;
  logic [31:0]   msg_data = '0;
  logic          msg_last = 1'b0;
  logic [1:0]    msg_last_bytes = '0;
  logic          msg_empty = 1'b0;
  logic          core_init;
  logic          core_next;
  logic [1023:0] core_block;
  logic          core_ready = 1'b1;
  logic          core_tag_valid = 1'b0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  hmac_msg_padder #(.LEN_W(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .zeroize        (zeroize),
    .start          (start),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .msg_data       (msg_data),
    .msg_last       (msg_last),
    .msg_last_bytes (msg_last_bytes),
    .msg_empty      (msg_empty),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_block     (core_block),
    .core_ready     (core_ready),
    .core_tag_valid (core_tag_valid),
    .busy           (busy),
    .done           (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core responder: records commands, holds ready low for a latency, checks stability.
  int            cyc = 0;
  int            hold_until = 0;
  int            lat_cfg = 3;
  int            lat_cnt = 0;
  logic          window = 1'b0;
  logic          prev_pulse = 1'b0;
  logic [1023:0] cur_blk = '0;
  int            stab_err = 0;
  int            rdy_err = 0;
  int            pulse_err = 0;
  int            pulse_in_hold = 0;
  logic [1023:0] got_blk[$];
  bit            got_init[$];
  logic          hold;
  assign hold = (cyc < hold_until);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_pulse <= core_init | core_next;
    if (window && core_block !== cur_blk) stab_err <= stab_err + 1;
    if (window && msg_ready) rdy_err <= rdy_err + 1;
    if (core_init || core_next) begin
      got_blk.push_back(core_block);
      got_init.push_back(core_init);
      if ((core_init && core_next) || prev_pulse) pulse_err <= pulse_err + 1;
      if (hold) pulse_in_hold <= pulse_in_hold + 1;
      cur_blk        <= core_block;
      window         <= 1'b1;
      lat_cnt        <= lat_cfg;
      core_ready     <= 1'b0;
      core_tag_valid <= 1'b0;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
    end else begin
      core_ready <= !hold;
      if (window) core_tag_valid <= 1'b1;
      if (window && core_ready && core_tag_valid) window <= 1'b0;
    end
  end

  // Reference model: message bytes, 0x80, zeros to 112 mod 128, 16-byte length.
  byte unsigned  mb[0:1023];
  logic [1023:0] exp_blk[$];

  task automatic build_exp(input int len);
    byte unsigned  q[$];
    logic [127:0]  lb;
    logic [1023:0] blk;
    for (int i = 0; i < len; i++) q.push_back(mb[i]);
    q.push_back(8'h80);
    while ((q.size() % 128) != 112) q.push_back(8'h00);
    lb = 128'(1024 + 8 * len);
    for (int k = 0; k < 16; k++) q.push_back(lb[127-8*k -: 8]);
    exp_blk.delete();
    for (int b = 0; b < q.size() / 128; b++) begin
      blk = '0;
      for (int i = 0; i < 128; i++) blk[1023-8*i -: 8] = q[128*b+i];
      exp_blk.push_back(blk);
    end
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i < 1024; i++) mb[i] = 8'($urandom);
  endtask

  // Starts a message of len bytes and feeds the first nsend words.
  task automatic send_words(input int len, input int nsend, input int gap_max);
    int nw;
    int t;
    nw = (len + 3) / 4;
    @(posedge clk); #1;
    start = 1'b1;
    msg_empty = (len == 0);
    @(posedge clk); #1;
    start = 1'b0;
    msg_empty = 1'b0;
    for (int w = 0; w < nsend; w++) begin
      msg_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
      msg_data = {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
      msg_last = (w == nw - 1);
      msg_last_bytes = 2'(len % 4);
      msg_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (msg_ready) break;
        t++;
        if (t > 5000) break;
      end
      if (t > 5000) begin
        check("msg_ready_timeout", 0, 1);
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  // Runs a whole message and compares every block and command with the model.
  task automatic run_msg(input string tag, input int len, input int gap_max);
    int base;
    int t;
    bit seen;
    base = got_blk.size();
    build_exp(len);
    send_words(len, (len + 3) / 4, gap_max);
    seen = 1'b0;
    for (t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 1024'(seen), 1);
    check({tag, "_nblocks"}, 1024'(got_blk.size() - base), 1024'(exp_blk.size()));
    for (int i = 0; i < exp_blk.size(); i++) begin
      if (base + i < got_blk.size()) begin
        check($sformatf("%s_blk%0d", tag, i), got_blk[base+i], exp_blk[i]);
        check($sformatf("%s_init%0d", tag, i), 1024'(got_init[base+i]), 1024'(i == 0));
      end
    end
    @(negedge clk);
    check({tag, "_idle"}, 1024'(busy), 0);
  endtask

  initial begin
    int base;
    randomize_bytes();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 1024'(busy), 0);
    check("rst_ready", 1024'(msg_ready), 0);
    check("rst_block", core_block, '0);
    check("rst_cmd", 1024'({core_init, core_next, done}), 0);
    reset_n = 1'b1;

    // Empty message.
    base = got_blk.size();
    run_msg("empty", 0, 0);
    if (got_blk.size() > base)
      check("empty_const", got_blk[base], {8'h80, 888'b0, 128'h400});

    // "abc" with garbage in the unused byte.
    mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63; mb[3] = 8'hff;
    base = got_blk.size();
    run_msg("abc", 3, 1);
    if (got_blk.size() > base)
      check("abc_const", got_blk[base], {32'h61626380, 864'b0, 128'h418});

    randomize_bytes();
    run_msg("len112", 112, 1);
    randomize_bytes();
    run_msg("len128", 128, 0);

    // Core not ready for a long stretch while the first block waits.
    randomize_bytes();
    lat_cfg = 6;
    hold_until = cyc + 150;
    run_msg("len300", 300, 0);
    check("hold_no_pulse", 1024'(pulse_in_hold), 0);
    lat_cfg = 3;

    // Zeroize mid-message.
    randomize_bytes();
    send_words(400, 10, 0);
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zero_busy", 1024'(busy), 0);
    check("zero_block", core_block, '0);
    check("zero_ready", 1024'(msg_ready), 0);
    mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63; mb[3] = 8'h00;
    base = got_blk.size();
    run_msg("abc_after_zero", 3, 0);
    if (got_blk.size() > base)
      check("abc2_const", got_blk[base], {32'h61626380, 864'b0, 128'h418});

    // Randomised lengths, gaps and core latency.
    for (int r = 0; r < 10; r++) begin
      randomize_bytes();
      lat_cfg = $urandom_range(1, 12);
      run_msg($sformatf("rand%0d", r), $urandom_range(0, 400), 3);
    end

    check("block_stable", 1024'(stab_err), 0);
    check("ready_low_in_wait", 1024'(rdy_err), 0);
    check("single_pulse", 1024'(pulse_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
